lcd_ctrl_win: RTL and testbench

Parametrised LCD image-window controller. Stores an IMG_H x IMG_W pixel image and emits a WIN x WIN display frame after every command. Supports a decimated "fit" view and a pannable "zoom" window, with four-way rotation in both modes. Sits between the host command interface and the LCD panel driver.

---
 rtl/lcd_ctrl_win.sv | 277 +++++++++++++++++++++++++++
 tb/tb_lcd_ctrl_win.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl_win.sv
// lcd_ctrl_win - LCD image-window controller.
//
// Stores an IMG_H x IMG_W image streamed in by a LOAD command and, after every
// accepted command, emits a WIN x WIN frame: either a decimated "fit" view of
// the whole image or a pannable 1:1 "zoom" window, rotated in 90-degree steps.
//
// Optional build macro: LCD_CTRL_MIRROR_EN adds a horizontal mirror flag that
// command 9 toggles. Without it, command 9 behaves like 10..15.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-high reset
//   cmd[3:0]     in   command code, captured when the command is accepted
//   cmd_valid    in   command strobe, accepted only while busy=0
//   datain       in   pixel stream, one pixel per cycle during LOAD
//   dataout      out  display pixel, holds its value between frames
//   output_valid out  dataout qualifier, high for WIN*WIN cycles per frame
//   busy         out  a command is being processed
module lcd_ctrl_win #(
  parameter int DW    = 8,
  parameter int IMG_W = 12,
  parameter int IMG_H = 9,
  parameter int WIN   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] datain,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int AW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int WW    = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int NW    = $clog2(WIN * WIN + 1);
  localparam int SR    = IMG_H / WIN;
  localparam int SC    = IMG_W / WIN;
  localparam int R_CTR = (IMG_H - WIN + 1) / 2;
  localparam int C_CTR = (IMG_W - WIN + 1) / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cmd_q, cmd_d;
  logic            zoom_q, zoom_d;
  logic [1:0]      orient_q, orient_d;
  logic [RW-1:0]   r0_q, r0_d;
  logic [CW-1:0]   c0_q, c0_d;
  logic [AW-1:0]   ld_cnt_q, ld_cnt_d;
  logic [WW-1:0]   u_q, u_d;
  logic [WW-1:0]   v_q, v_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   dout_q, dout_d;
`ifdef LCD_CTRL_MIRROR_EN
  logic            mirror_q, mirror_d;
`endif

  logic            mem_we_s;
  logic [AW-1:0]   rd_addr_s;
  logic [DW-1:0]   mem [NPIX];

  // Image storage: written only during LOAD, never reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[ld_cnt_q] <= datain;
    end
  end

  // Source address of the display pixel (u_q, v_q) for the current view.
  always_comb begin : addr_calc
    int u, v, vm, i, j, row, col;
    u = int'(u_q);
    v = int'(v_q);
`ifdef LCD_CTRL_MIRROR_EN
    vm = mirror_q ? (WIN - 1 - v) : v;
`else
    vm = v;
`endif
    // Orientation maps display (u, vm) back to window coordinates (i, j).
    case (orient_q)
      2'd0:    begin i = u;           j = vm;           end
      2'd1:    begin i = WIN - 1 - vm; j = u;           end
      2'd2:    begin i = WIN - 1 - u;  j = WIN - 1 - vm; end
      2'd3:    begin i = vm;          j = WIN - 1 - u;  end
      default: begin i = u;           j = vm;           end
    endcase
    if (zoom_q) begin
      row = int'(r0_q) + i;
      col = int'(c0_q) + j;
    end else begin
      row = SR / 2 + i * SR;
      col = SC / 2 + j * SC;
    end
    rd_addr_s = AW'(row * IMG_W + col);
  end

  // Next-state and output logic of the command sequencer.
  always_comb begin : next_state
    int dr, dc, nr, nc;
    state_d  = state_q;
    cmd_d    = cmd_q;
    zoom_d   = zoom_q;
    orient_d = orient_q;
    r0_d     = r0_q;
    c0_d     = c0_q;
    ld_cnt_d = ld_cnt_q;
    u_d      = u_q;
    v_d      = v_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    dout_d   = dout_q;
`ifdef LCD_CTRL_MIRROR_EN
    mirror_d = mirror_q;
`endif
    mem_we_s = 1'b0;
    dr = 0;
    dc = 0;
    nr = 0;
    nc = 0;

    case (state_q)
      S_IDLE: begin
        // busy is low only here, so IDLE plus cmd_valid is an acceptance.
        if (cmd_valid) begin
          cmd_d    = cmd;
          busy_d   = 1'b1;
          ld_cnt_d = '0;
          state_d  = (cmd == 4'd0) ? S_LOAD : S_EXEC;
        end
      end

      S_LOAD: begin
        mem_we_s = 1'b1;
        ld_cnt_d = ld_cnt_q + AW'(1);
        if (ld_cnt_q == AW'(NPIX - 1)) begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (cmd_q)
          4'd0: begin
            zoom_d   = 1'b0;
            orient_d = 2'd0;
            r0_d     = RW'(R_CTR);
            c0_d     = CW'(C_CTR);
`ifdef LCD_CTRL_MIRROR_EN
            mirror_d = 1'b0;
`endif
          end
          4'd1: orient_d = orient_q - 2'd1;
          4'd2: orient_d = orient_q + 2'd1;
          4'd3: begin
            zoom_d = 1'b1;
            r0_d   = RW'(R_CTR);
            c0_d   = CW'(C_CTR);
          end
          4'd4: zoom_d = 1'b0;
          4'd5, 4'd6, 4'd7, 4'd8: begin
            // Display step (dr, dc) for R/L/U/D, then rotated into the
            // image frame by the current orientation.
            case (cmd_q)
              4'd5:    begin dr = 0;  dc = 1;  end
              4'd6:    begin dr = 0;  dc = -1; end
              4'd7:    begin dr = -1; dc = 0;  end
              default: begin dr = 1;  dc = 0;  end
            endcase
            case (orient_q)
              2'd0:    begin nr = dr;  nc = dc;  end
              2'd1:    begin nr = -dc; nc = dr;  end
              2'd2:    begin nr = -dr; nc = -dc; end
              default: begin nr = dc;  nc = -dr; end
            endcase
            nr = int'(r0_q) + nr;
            nc = int'(c0_q) + nc;
            // A step that would leave the image is simply dropped.
            if (zoom_q && nr >= 0 && nr <= IMG_H - WIN) begin
              r0_d = RW'(nr);
            end else begin
              r0_d = r0_q;
            end
            if (zoom_q && nc >= 0 && nc <= IMG_W - WIN) begin
              c0_d = CW'(nc);
            end else begin
              c0_d = c0_q;
            end
          end
`ifdef LCD_CTRL_MIRROR_EN
          4'd9: mirror_d = ~mirror_q;
`endif
          default: ;
        endcase
        u_d     = '0;
        v_d     = '0;
        cnt_d   = '0;
        state_d = S_OUT;
      end

      S_OUT: begin
        if (cnt_q == NW'(WIN * WIN)) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          valid_d = 1'b1;
          dout_d  = mem[rd_addr_s];
          cnt_d   = cnt_q + NW'(1);
          if (v_q == WW'(WIN - 1)) begin
            v_d = '0;
            u_d = u_q + WW'(1);
          end else begin
            v_d = v_q + WW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any command immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cmd_q    <= 4'd0;
      zoom_q   <= 1'b0;
      orient_q <= 2'd0;
      r0_q     <= RW'(R_CTR);
      c0_q     <= CW'(C_CTR);
      ld_cnt_q <= '0;
      u_q      <= '0;
      v_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
`ifdef LCD_CTRL_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      zoom_q   <= zoom_d;
      orient_q <= orient_d;
      r0_q     <= r0_d;
      c0_q     <= c0_d;
      ld_cnt_q <= ld_cnt_d;
      u_q      <= u_d;
      v_q      <= v_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
`ifdef LCD_CTRL_MIRROR_EN
      mirror_q <= mirror_d;
`endif
    end
  end

  assign dataout      = dout_q;
  assign output_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_lcd_ctrl_win.sv
module tb_lcd_ctrl_win;

  localparam int DW    = 8;
  localparam int IMG_W = 12;
  localparam int IMG_H = 9;
  localparam int WIN   = 4;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int SR    = IMG_H / WIN;
  localparam int SC    = IMG_W / WIN;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    cmd = 4'd0;
  logic          cmd_valid = 1'b0;
  logic [DW-1:0] datain = '0;
  logic [DW-1:0] dataout;
  logic          output_valid;
  logic          busy;

  lcd_ctrl_win #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .datain(datain), .dataout(dataout), .output_valid(output_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  // Reference model state
  int img[NPIX];
  int newimg[NPIX];
  int m_zoom, m_orient, m_r0, m_c0, m_mirror;
  int w[WIN][WIN];
  int t[WIN][WIN];
  int lit_fit[16] = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};
  // Image-coordinate step for display directions R,L,U,D per orientation
  int tdr[4][4] = '{'{0, 0, -1, 1}, '{-1, 1, 0, 0}, '{0, 0, 1, -1}, '{1, -1, 0, 0}};
  int tdc[4][4] = '{'{1, -1, 0, 0}, '{0, 0, -1, 1}, '{-1, 1, 0, 0}, '{0, 0, 1, -1}};

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_zoom = 0; m_orient = 0; m_mirror = 0;
    m_r0 = (IMG_H - WIN + 1) / 2;
    m_c0 = (IMG_W - WIN + 1) / 2;
  endtask

  task automatic model_apply(input int c);
    int nr, nc;
    case (c)
      0: begin
        for (int k = 0; k < NPIX; k++) img[k] = newimg[k];
        model_reset();
      end
      1: m_orient = (m_orient + 3) % 4;
      2: m_orient = (m_orient + 1) % 4;
      3: begin
        m_zoom = 1;
        m_r0 = (IMG_H - WIN + 1) / 2;
        m_c0 = (IMG_W - WIN + 1) / 2;
      end
      4: m_zoom = 0;
      5, 6, 7, 8: if (m_zoom == 1) begin
        nr = m_r0 + tdr[m_orient][c-5];
        nc = m_c0 + tdc[m_orient][c-5];
        if (nr >= 0 && nr <= IMG_H - WIN) m_r0 = nr;
        if (nc >= 0 && nc <= IMG_W - WIN) m_c0 = nc;
      end
`ifdef LCD_CTRL_MIRROR_EN
      9: m_mirror = 1 - m_mirror;
`endif
      default: ;
    endcase
  endtask

  // Cut the window, rotate it clockwise orient times, mirror, push raster.
  task automatic push_frame();
    for (int i = 0; i < WIN; i++)
      for (int j = 0; j < WIN; j++)
        if (m_zoom == 1) w[i][j] = img[(m_r0 + i) * IMG_W + m_c0 + j];
        else             w[i][j] = img[(SR / 2 + i * SR) * IMG_W + SC / 2 + j * SC];
    for (int r = 0; r < m_orient; r++) begin
      for (int u = 0; u < WIN; u++)
        for (int v = 0; v < WIN; v++)
          t[u][v] = w[WIN-1-v][u];
      w = t;
    end
    for (int u = 0; u < WIN; u++)
      for (int v = 0; v < WIN; v++)
        exp_q.push_back((m_mirror == 1) ? w[u][WIN-1-v] : w[u][v]);
  endtask

  // Monitor: every displayed pixel must match the head of the scoreboard.
  int mon_e;
  always @(negedge clk) begin
    if (!reset && output_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pixel got=%0d expected=none", dataout);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(dataout) != mon_e) begin
          failures++;
          $display("FAIL pixel got=%0d expected=%0d", dataout, mon_e);
        end
      end
    end
  end

  // Issue one command (called at posedge+#1) and check its timing.
  task automatic issue(input int c, input bit lit, input int pulse_at, input int reset_at);
    int n, first_v, k;
    k = 0;
    while (busy && k < 400) begin
      @(posedge clk); #1; k++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    cmd = 4'(c);
    cmd_valid = 1'b1;
    model_apply(c);
    if (lit) begin
      for (int p = 0; p < 16; p++) exp_q.push_back(lit_fit[p]);
    end else begin
      push_frame();
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("busy_rise", int'(busy), 1);
    if (c == 0) datain = DW'(newimg[0]);
    n = 0;
    first_v = -1;
    while (n < 400) begin
      @(posedge clk); #1; n++;
      if (c == 0 && n < NPIX) datain = DW'(newimg[n]);
      if (output_valid && first_v < 0) first_v = n;
      if (n == pulse_at) begin cmd = 4'd8; cmd_valid = 1'b1; end
      if (n == pulse_at + 1) cmd_valid = 1'b0;
      if (n == reset_at) begin
        reset = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(output_valid), 0);
        chk("rst_dataout", int'(dataout), 0);
        break;
      end
      if (!busy) break;
    end
    if (n == reset_at) begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      model_reset();
    end else begin
      if (busy) chk("frame_timeout", 1, 0);
      chk("first_valid_cycle", first_v, (c == 0) ? NPIX + 2 : 2);
      chk("busy_cycles", n, ((c == 0) ? NPIX + 2 : 2) + WIN * WIN);
      chk("frame_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(output_valid), 0);
    chk("reset_dataout", int'(dataout), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Pixel value = address
    for (int k = 0; k < NPIX; k++) newimg[k] = k;
    issue(0, 1'b1, -10, -10);
    issue(3, 1'b0, -10, -10);
    repeat (10) issue(5, 1'b0, -10, -10);
    issue(4, 1'b0, -10, -10);
    issue(3, 1'b0, -10, -10);
    issue(2, 1'b0, -10, -10);
    issue(5, 1'b0, -10, -10);
    issue(0, 1'b0, -10, -10);
    repeat (5) issue(1, 1'b0, -10, -10);
    issue(0, 1'b0, -10, -10);
    issue(9, 1'b0, -10, -10);
    issue(12, 1'b0, -10, -10);
    issue(3, 1'b0, -10, -10);
    repeat (3) issue(8, 1'b0, -10, -10);
    issue(7, 1'b0, -10, -10);
    issue(6, 1'b0, -10, -10);

    // SHIFT_D pulsed mid-frame must be ignored
    issue(6, 1'b0, 5, -10);
    repeat (5) begin
      @(posedge clk); #1;
      chk("ignored_cmd_busy", int'(busy), 0);
    end

    // Reset while pixel 5 is displayed, then fit frame from stored image
    issue(4, 1'b0, -10, 7);
    issue(4, 1'b0, -10, -10);

    // Randomized phase with occasional reloads of random images
    repeat (60) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int k = 0; k < NPIX; k++) newimg[k] = int'($urandom_range(0, 255));
        issue(0, 1'b0, -10, -10);
      end else begin
        issue(int'($urandom_range(1, 15)), 1'b0, -10, -10);
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty_end", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
